// File: rtl/mixcolumns.sv
// Column-serial AES-128 MixColumns stage.
//
// Captures a 16-byte state (column-major, a0 = row 0 of column 0) and computes one
// 4-byte column per clock. After four columns, all sixteen result bytes are loaded
// into b0..b15 together, and done pulses for one cycle.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        start request; sampled in IDLE or DONE, ignored in CALC
//   a0..a15   input state bytes from ShiftRows
//   b0..b15   registered MixColumns result; changes only on the edge that raises done
//   done      registered one-cycle pulse when a new result is valid
//   busy      registered; high from the capture edge until the result edge
module mixcolumns (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] a0,
  input  logic [7:0] a1,
  input  logic [7:0] a2,
  input  logic [7:0] a3,
  input  logic [7:0] a4,
  input  logic [7:0] a5,
  input  logic [7:0] a6,
  input  logic [7:0] a7,
  input  logic [7:0] a8,
  input  logic [7:0] a9,
  input  logic [7:0] a10,
  input  logic [7:0] a11,
  input  logic [7:0] a12,
  input  logic [7:0] a13,
  input  logic [7:0] a14,
  input  logic [7:0] a15,
  output logic [7:0] b0,
  output logic [7:0] b1,
  output logic [7:0] b2,
  output logic [7:0] b3,
  output logic [7:0] b4,
  output logic [7:0] b5,
  output logic [7:0] b6,
  output logic [7:0] b7,
  output logic [7:0] b8,
  output logic [7:0] b9,
  output logic [7:0] b10,
  output logic [7:0] b11,
  output logic [7:0] b12,
  output logic [7:0] b13,
  output logic [7:0] b14,
  output logic [7:0] b15,
  output logic       done,
  output logic       busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // GF(2^8) multiply by 2 with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Column in/out packed with row 0 in the least significant byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] x0, x1, x2, x3;
    logic [7:0] r0, r1, r2, r3;
    x0 = col[7:0];
    x1 = col[15:8];
    x2 = col[23:16];
    x3 = col[31:24];
    r0 = xtime(x0) ^ (xtime(x1) ^ x1) ^ x2 ^ x3;
    r1 = x0 ^ xtime(x1) ^ (xtime(x2) ^ x2) ^ x3;
    r2 = x0 ^ x1 ^ xtime(x2) ^ (xtime(x3) ^ x3);
    r3 = (xtime(x0) ^ x0) ^ x1 ^ x2 ^ xtime(x3);
    return {r3, r2, r1, r0};
  endfunction

  logic [1:0]   state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] in_q, in_d;
  logic [127:0] res_q, res_d;
  logic [127:0] b_q, b_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic [127:0] a_flat;
  logic [31:0]  col_res;

  assign a_flat = {a15, a14, a13, a12, a11, a10, a9, a8, a7, a6, a5, a4, a3, a2, a1, a0};
  assign col_res = mix_col(in_q[32*col_q +: 32]);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    in_d    = in_q;
    res_d   = res_q;
    b_d     = b_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      // DONE accepts a new block just like IDLE, giving back-to-back operation.
      StIdle, StDone: begin
        if (en) begin
          in_d    = a_flat;
          col_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = StCalc;
        end else begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StCalc: begin
        res_d[32*col_q +: 32] = col_res;
        if (col_q == 2'd3) begin
          // Column 3 bypasses the result register so b loads on this same edge.
          b_d     = {col_res, res_q[95:0]};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StDone;
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      col_q   <= 2'd0;
      in_q    <= '0;
      res_q   <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      in_q    <= in_d;
      res_q   <= res_d;
      b_q     <= b_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign done = done_q;
  assign busy = busy_q;

  assign b0  = b_q[7:0];
  assign b1  = b_q[15:8];
  assign b2  = b_q[23:16];
  assign b3  = b_q[31:24];
  assign b4  = b_q[39:32];
  assign b5  = b_q[47:40];
  assign b6  = b_q[55:48];
  assign b7  = b_q[63:56];
  assign b8  = b_q[71:64];
  assign b9  = b_q[79:72];
  assign b10 = b_q[87:80];
  assign b11 = b_q[95:88];
  assign b12 = b_q[103:96];
  assign b13 = b_q[111:104];
  assign b14 = b_q[119:112];
  assign b15 = b_q[127:120];

endmodule

// File: tb/tb_mixcolumns.sv
// Randomized self-checking bench for mixcolumns against a matrix-form GF(2^8) model.
module tb_mixcolumns;

  logic         clk;
  logic         rst;
  logic         en;
  logic [127:0] a_v;
  logic [7:0]   b0, b1, b2, b3, b4, b5, b6, b7, b8, b9, b10, b11, b12, b13, b14, b15;
  logic         done;
  logic         busy;
  logic [127:0] b_v;

  int n_checks;
  int n_errors;

  assign b_v = {b15, b14, b13, b12, b11, b10, b9, b8, b7, b6, b5, b4, b3, b2, b1, b0};

  mixcolumns dut (
    .clk(clk), .rst(rst), .en(en),
    .a0(a_v[7:0]),     .a1(a_v[15:8]),    .a2(a_v[23:16]),   .a3(a_v[31:24]),
    .a4(a_v[39:32]),   .a5(a_v[47:40]),   .a6(a_v[55:48]),   .a7(a_v[63:56]),
    .a8(a_v[71:64]),   .a9(a_v[79:72]),   .a10(a_v[87:80]),  .a11(a_v[95:88]),
    .a12(a_v[103:96]), .a13(a_v[111:104]), .a14(a_v[119:112]), .a15(a_v[127:120]),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .b7(b7),
    .b8(b8), .b9(b9), .b10(b10), .b11(b11), .b12(b12), .b13(b13), .b14(b14), .b15(b15),
    .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // General GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] x, input int k);
    logic [7:0] p, v;
    p = 8'h00;
    v = x;
    for (int i = 0; i < 8; i++) begin
      if (((k >> i) & 1) != 0) p ^= v;
      v = v[7] ? ((v << 1) ^ 8'h1b) : (v << 1);
    end
    return p;
  endfunction

  // Circulant matrix product per column.
  function automatic logic [127:0] model(input logic [127:0] st);
    int         coef[4];
    logic [7:0] r;
    logic [127:0] o;
    coef = '{2, 3, 1, 1};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++) r ^= gmul(st[32*c + 8*j +: 8], coef[(j - i + 4) % 4]);
        o[32*c + 8*i +: 8] = r;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one block from IDLE and check the full E0..E5 timing and result.
  task automatic run_block(input string tag, input logic [127:0] v);
    logic [127:0] exp;
    exp = model(v);
    a_v = v;
    en  = 1'b1;
    tick();  // E0
    en  = 1'b0;
    a_v = rand128();  // inputs may change after capture
    check({tag, " busy_e0"}, busy, 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      check({tag, " busy_calc"}, busy, 1);
      check({tag, " done_early"}, done, 0);
    end
    tick();  // E4
    check({tag, " done_e4"}, done, 1);
    check({tag, " busy_e4"}, busy, 0);
    check({tag, " b"}, b_v, exp);
    tick();  // E5
    check({tag, " done_e5"}, done, 0);
    check({tag, " b_hold"}, b_v, exp);
  endtask

  logic [127:0] kat_in, kat_out, c6;
  logic [31:0]  col_in[4], col_out[4];
  logic [127:0] v, v2;

  initial begin
    n_checks = 0;
    n_errors = 0;
    kat_in  = 128'he598271ef11141b8ae52b4e0305dbfd4;
    kat_out = 128'h4c2606287ad3f8489a19cbe0e5816604;
    c6      = {16{8'hc6}};
    col_in  = '{32'h455313db, 32'h5c220af2, 32'h01010101, 32'hd5d4d4d4};
    col_out = '{32'hbca14d8e, 32'h9d58dc9f, 32'h01010101, 32'hd6d7d5d5};

    // Reset with en high and random inputs.
    rst = 1'b1;
    en  = 1'b1;
    a_v = rand128();
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_b", b_v, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      a_v = rand128();
    end
    rst = 1'b0;
    en  = 1'b0;
    tick();

    // Known-answer, checked against both the constant and the model.
    check("model_kat", model(kat_in), kat_out);
    run_block("kat", kat_in);
    check("kat_const", b_v, kat_out);

    // Single-column vectors in each column position.
    for (int c = 0; c < 4; c++) begin
      v = rand128();
      v[32*c +: 32] = col_in[c];
      run_block("col", v);
      check("col_const", {96'h0, b_v[32*c +: 32]}, {96'h0, col_out[c]});
    end

    // Back-to-back with en held high.
    a_v = kat_in;
    en  = 1'b1;
    tick();  // E0
    a_v = c6;
    for (int k = 1; k < 4; k++) begin
      tick();
      check("b2b_busy1", busy, 1);
      check("b2b_nodone1", done, 0);
    end
    tick();  // E4
    check("b2b_done1", done, 1);
    check("b2b_busy_e4", busy, 0);
    check("b2b_b1", b_v, kat_out);
    tick();  // E5 captures c6
    check("b2b_done_e5", done, 0);
    check("b2b_busy_e5", busy, 1);
    for (int k = 6; k < 9; k++) begin
      tick();
      check("b2b_busy2", busy, 1);
      check("b2b_nodone2", done, 0);
    end
    tick();  // E9
    en = 1'b0;
    check("b2b_done2", done, 1);
    check("b2b_b2", b_v, c6);
    tick();
    check("b2b_done_e10", done, 0);
    check("b2b_idle_busy", busy, 0);

    // en pulsed during CALC is ignored.
    v  = rand128();
    v2 = rand128();
    a_v = v;
    en  = 1'b1;
    tick();  // E0
    en  = 1'b0;
    tick();  // E1
    a_v = v2;
    en  = 1'b1;
    tick();  // E2
    en  = 1'b0;
    check("ign_done_e2", done, 0);
    tick();  // E3
    check("ign_done_e3", done, 0);
    tick();  // E4
    check("ign_done_e4", done, 1);
    check("ign_b", b_v, model(v));
    tick();
    check("ign_idle_busy", busy, 0);

    // Reset at E2 abandons the block.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_v = rand128();
    en  = 1'b1;
    tick();  // E0
    en  = 1'b0;
    tick();  // E1
    rst = 1'b1;
    tick();  // E2
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    for (int k = 0; k < 8; k++) begin
      check("midrst_done", done, 0);
      check("midrst_b", b_v, 0);
      tick();
    end
    run_block("after_rst", rand128());

    // Random blocks.
    for (int n = 0; n < 20; n++) begin
      run_block("rand", rand128());
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
